// File: rtl/hyperbus_trx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_trx_arbiter
// Brief    : Round-robin arbiter sharing the HyperBus PHY transaction port.
// Revision : 1.0
// ============================================================================
module hyperbus_trx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int NUM_CHIPS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int CHIP_ADDR_LSB = 23,
    parameter int IDX_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_phy_i,
    input  logic                          rst_phy_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    output logic                          trans_valid_o,
    input  logic                          trans_ready_i,
    output logic [ADDR_WIDTH-1:0]         trans_addr_o,
    output logic [LEN_WIDTH-1:0]          trans_len_o,
    output logic                          trans_write_o,
    output logic [NUM_CHIPS-1:0]          trans_cs_o,
    output logic [IDX_WIDTH-1:0]          trans_src_o,
    input  logic                          trans_done_i,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic                          busy_o
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_error = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_addr_mask =
        ADDR_WIDTH'((64'd1 << CHIP_ADDR_LSB) - 64'd1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_rr;
    logic [IDX_WIDTH-1:0]  w_rr_nxt;
    logic [IDX_WIDTH-1:0]  w_winner;
    logic                  w_found;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_chip_hi;
    logic                  w_decode_err;
    logic [NUM_CHIPS-1:0]  w_cs;
    logic [NUM_REQ-1:0]    r_done;

    // Search starts at the round-robin pointer and wraps around.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid_i[idx]) begin
                w_found  = 1'b1;
                w_winner = IDX_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        w_rr_nxt = w_winner + 1'b1;
        if (int'(w_winner) + 1 >= NUM_REQ) begin
            w_rr_nxt = '0;
        end
    end

    assign w_grant      = (r_state == c_st_idle) && w_found;
    assign w_addr       = req_addr_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_chip_hi    = w_addr >> CHIP_ADDR_LSB;
    assign w_decode_err = (w_chip_hi >= ADDR_WIDTH'(NUM_CHIPS));
    // Only meaningful when the decode is in range, which bounds the shift.
    assign w_cs         = NUM_CHIPS'(1) << w_chip_hi;

    always_ff @(posedge clk_phy_i or negedge rst_phy_ni) begin
        if (!rst_phy_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state_nxt = w_decode_err ? c_st_error : c_st_issue;
                end
            end
            c_st_issue: begin
                if (trans_ready_i) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (trans_done_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready_o   = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
        trans_valid_o = (r_state == c_st_issue);
        err_o         = (r_state == c_st_error) ? (NUM_REQ'(1) << trans_src_o) : '0;
        busy_o        = (r_state != c_st_idle);
        done_o        = r_done;
    end

    always_ff @(posedge clk_phy_i or negedge rst_phy_ni) begin
        if (!rst_phy_ni) begin
            r_rr          <= '0;
            trans_addr_o  <= '0;
            trans_len_o   <= '0;
            trans_write_o <= 1'b0;
            trans_cs_o    <= '0;
            trans_src_o   <= '0;
            r_done        <= '0;
        end else begin
            if (w_grant) begin
                r_rr          <= w_rr_nxt;
                trans_addr_o  <= w_addr & c_addr_mask;
                trans_len_o   <= req_len_i[w_winner*LEN_WIDTH +: LEN_WIDTH];
                trans_write_o <= req_write_i[w_winner];
                trans_cs_o    <= w_decode_err ? '0 : w_cs;
                trans_src_o   <= w_winner;
            end
            r_done <= ((r_state == c_st_wait) && trans_done_i) ?
                      (NUM_REQ'(1) << trans_src_o) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_trx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperbus_trx_arbiter
// Brief    : Table-driven, scoreboarded bench for hyperbus_trx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_hyperbus_trx_arbiter;

    logic        clk_phy_i = 1'b0;
    logic        rst_phy_ni = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready_o;
    logic [63:0] req_addr = '0;
    logic [31:0] req_len = '0;
    logic [1:0]  req_write = '0;
    logic        trans_valid_o;
    logic        trans_ready_i = 1'b0;
    logic [31:0] trans_addr_o;
    logic [15:0] trans_len_o;
    logic        trans_write_o;
    logic [1:0]  trans_cs_o;
    logic [0:0]  trans_src_o;
    logic        trans_done_i = 1'b0;
    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic        busy_o;
    logic [59:0] all_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [15:0] l0;
        logic [15:0] l1;
        logic [1:0]  wr;
        int          win;
        bit          err;
        logic [1:0]  cs;
        logic [31:0] addr;
        int          hold;
        bit          dii;
    } vec_t;

    typedef struct {
        bit          is_err;
        int          src;
        logic [1:0]  cs;
        logic [31:0] addr;
        logic [15:0] len;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    hyperbus_trx_arbiter dut (
        .clk_phy_i     (clk_phy_i),
        .rst_phy_ni    (rst_phy_ni),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr),
        .req_len_i     (req_len),
        .req_write_i   (req_write),
        .trans_valid_o (trans_valid_o),
        .trans_ready_i (trans_ready_i),
        .trans_addr_o  (trans_addr_o),
        .trans_len_o   (trans_len_o),
        .trans_write_o (trans_write_o),
        .trans_cs_o    (trans_cs_o),
        .trans_src_o   (trans_src_o),
        .trans_done_i  (trans_done_i),
        .done_o        (done_o),
        .err_o         (err_o),
        .busy_o        (busy_o)
    );

    assign all_out = {req_ready_o, trans_valid_o, trans_addr_o, trans_len_o, trans_write_o,
                      trans_cs_o, trans_src_o, done_o, err_o, busy_o};

    always #5 clk_phy_i = ~clk_phy_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PHY-side monitor: pops the scoreboard on every handshake or error pulse.
    always @(negedge clk_phy_i) begin
        if (rst_phy_ni === 1'b1 && ((trans_valid_o && trans_ready_i) || err_o != 2'b00)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: valid %b err %b with empty scoreboard",
                         trans_valid_o, err_o);
            end else begin
                exp_t e;
                logic [1:0] exp_err;
                e = sb.pop_front();
                exp_err = e.is_err ? (2'b01 << e.src) : 2'b00;
                if (err_o != 2'b00) begin
                    check("err_pulse", {err_o, trans_valid_o, trans_src_o},
                          {exp_err, 1'b0, e.src[0]});
                end else begin
                    check("trans_fields",
                          {~e.is_err, trans_src_o, trans_cs_o, trans_write_o, trans_len_o, trans_addr_o},
                          {1'b1, e.src[0], e.cs, e.wr, e.len, e.addr});
                end
            end
        end
    end

    task automatic run_row(input vec_t v, input string tag);
        int   cyc;
        exp_t e;
        @(posedge clk_phy_i); #1;
        req_valid = v.valid;
        req_addr  = {v.a1, v.a0};
        req_len   = {v.l1, v.l0};
        req_write = v.wr;
        cyc = 0;
        @(negedge clk_phy_i);
        while (req_ready_o == 2'b00 && cyc < 20) begin
            @(negedge clk_phy_i);
            cyc++;
        end
        check({tag, "_grant"}, req_ready_o, 2'b01 << v.win);
        if (cyc >= 20) begin
            req_valid = '0;
            return;
        end
        e.is_err = v.err;
        e.src    = v.win;
        e.cs     = v.cs;
        e.addr   = v.addr;
        e.len    = (v.win == 1) ? v.l1 : v.l0;
        e.wr     = v.wr[v.win];
        sb.push_back(e);
        @(posedge clk_phy_i); #1;
        req_valid = '0;
        if (v.err) begin
            @(negedge clk_phy_i);
            check({tag, "_err_busy"}, {busy_o, trans_valid_o}, 2'b10);
            @(negedge clk_phy_i);
            check({tag, "_err_end"}, {busy_o, err_o, trans_valid_o}, 0);
            return;
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk_phy_i);
            check({tag, "_backpressure"}, {trans_valid_o, req_ready_o, done_o, trans_addr_o},
                  {1'b1, 2'b00, 2'b00, v.addr});
            @(posedge clk_phy_i); #1;
            trans_done_i = (v.dii && h == 1);
        end
        trans_ready_i = 1'b1;
        trans_done_i  = v.dii;
        @(posedge clk_phy_i); #1;
        trans_ready_i = 1'b0;
        trans_done_i  = 1'b0;
        @(negedge clk_phy_i);
        check({tag, "_wait_done"}, {busy_o, trans_valid_o, done_o, trans_cs_o},
              {1'b1, 1'b0, 2'b00, v.cs});
        @(posedge clk_phy_i); #1;
        trans_done_i = 1'b1;
        @(posedge clk_phy_i); #1;
        trans_done_i = 1'b0;
        @(negedge clk_phy_i);
        check({tag, "_done"}, {done_o, busy_o}, {2'b01 << v.win, 1'b0});
        @(negedge clk_phy_i);
        check({tag, "_done_end"}, done_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        tbl[0]  = '{2'b01, 32'h0000_0100, 32'h0, 16'd7, 16'd0, 2'b01, 0, 1'b0, 2'b01, 32'h100, 0, 1'b0};
        tbl[1]  = '{2'b10, 32'h0, 32'h0080_0040, 16'd0, 16'd3, 2'b00, 1, 1'b0, 2'b10, 32'h40, 1, 1'b0};
        tbl[2]  = '{2'b11, 32'h0000_0200, 32'h0000_0300, 16'd1, 16'd2, 2'b10, 0, 1'b0, 2'b01, 32'h200, 0, 1'b0};
        tbl[3]  = '{2'b11, 32'h0000_0200, 32'h0000_0300, 16'd1, 16'd2, 2'b10, 1, 1'b0, 2'b01, 32'h300, 0, 1'b0};
        tbl[4]  = '{2'b11, 32'h0080_0000, 32'h0000_0004, 16'h10, 16'h20, 2'b01, 0, 1'b0, 2'b10, 32'h0, 0, 1'b0};
        tbl[5]  = '{2'b11, 32'h0080_0000, 32'h0000_0004, 16'h10, 16'h20, 2'b01, 1, 1'b0, 2'b01, 32'h4, 0, 1'b0};
        tbl[6]  = '{2'b10, 32'h0, 32'h0100_0000, 16'd0, 16'd5, 2'b10, 1, 1'b1, 2'b00, 32'h0, 0, 1'b0};
        tbl[7]  = '{2'b01, 32'h007F_FFFC, 32'h0, 16'hFFFF, 16'd0, 2'b01, 0, 1'b0, 2'b01, 32'h7F_FFFC, 5, 1'b1};
        tbl[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0090_0000, 16'd9, 16'd4, 2'b00, 1, 1'b0, 2'b10, 32'h10_0000, 0, 1'b0};
        tbl[9]  = '{2'b01, 32'hFFFF_FFFF, 32'h0, 16'd9, 16'd0, 2'b00, 0, 1'b1, 2'b00, 32'h0, 0, 1'b0};
        tbl[10] = '{2'b10, 32'h0, 32'h00FF_FFFF, 16'd0, 16'd0, 2'b10, 1, 1'b0, 2'b10, 32'h7F_FFFF, 2, 1'b0};

        repeat (2) @(negedge clk_phy_i);
        check("reset_outputs", all_out, 0);
        @(posedge clk_phy_i); #1;
        rst_phy_ni = 1'b1;
        @(negedge clk_phy_i);
        check("idle_outputs", all_out, 0);

        for (int i = 0; i < 11; i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        // Reset while waiting for completion: rr is 1 at this point.
        @(posedge clk_phy_i); #1;
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0080_1000};
        req_len   = {16'd0, 16'd4};
        req_write = 2'b01;
        @(negedge clk_phy_i);
        check("rst_seq_grant", req_ready_o, 2'b01);
        e = '{1'b0, 0, 2'b10, 32'h1000, 16'd4, 1'b1};
        sb.push_back(e);
        @(posedge clk_phy_i); #1;
        req_valid     = '0;
        trans_ready_i = 1'b1;
        @(posedge clk_phy_i); #1;
        trans_ready_i = 1'b0;
        @(negedge clk_phy_i);
        check("rst_seq_wait", {busy_o, trans_valid_o, trans_cs_o}, {1'b1, 1'b0, 2'b10});
        #2;
        rst_phy_ni   = 1'b0;
        trans_done_i = 1'b1;
        #1;
        check("async_reset", all_out, 0);
        @(posedge clk_phy_i); #1;
        trans_done_i = 1'b0;
        @(posedge clk_phy_i); #1;
        rst_phy_ni = 1'b1;
        @(negedge clk_phy_i);
        check("post_reset_idle", all_out, 0);
        @(negedge clk_phy_i);
        check("post_reset_no_done", {done_o, err_o, busy_o}, 0);

        run_row('{2'b11, 32'h0000_0008, 32'h0000_000C, 16'd2, 16'd3, 2'b11, 0, 1'b0, 2'b01, 32'h8, 0, 1'b0},
                "post_reset_rr");

        repeat (2) @(negedge clk_phy_i);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
